// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the display scheduler and its arbiter.
package display_scheduler_pkg;

    // Width of one requester value as shown on the six-digit display.
    localparam int VALUE_W = 16;

    // One second at a 50 MHz system clock.
    localparam int DISP_HOLD_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        ACK  = 2'd2
    } disp_sched_state_t;

endpackage

// File: rtl/display_scheduler_rr_pick.sv
// Combinational round-robin selector: returns the first set request bit at or
// after ptr, wrapping modulo N (N need not be a power of two).
module display_scheduler_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int            c;
            logic [IW-1:0] ci;
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            ci = IW'(c);
            if (req[ci]) begin
                found = 1'b1;
                idx   = ci;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the seven-segment display between NUM_REQ requesters.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; last value stays on the display
//   SHOW  | granted value is on the display, hold counter running
//   ACK   | one-cycle ack pulse to the granted requester, pointer advances
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int HOLD_CYCLES = DISP_HOLD_DEFAULT,
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1),
    localparam int GW          = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0][VALUE_W-1:0]   req_value,
    input  logic                              clear,
    output logic [NUM_REQ-1:0]                ack,
    output logic [VALUE_W-1:0]                disp_value,
    output logic                              disp_print,
    output logic [GW-1:0]                     grant_id,
    output logic                              busy
);

    disp_sched_state_t  state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [VALUE_W-1:0] value_d;
    logic               print_d;
    logic [GW-1:0]      gid_d;
    logic [NUM_REQ-1:0] ack_d;
    logic               busy_d;
    logic               pick_found;
    logic [GW-1:0]      pick_idx;

    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] i);
        if (i == GW'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    display_scheduler_rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State, hold counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        value_d = disp_value;
        print_d = disp_print;
        gid_d   = grant_id;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                // clear outranks a same-cycle request; arbitration resumes next cycle
                if (clear) begin
                    print_d = 1'b0;
                end else if (pick_found) begin
                    value_d = req_value[pick_idx];
                    gid_d   = pick_idx;
                    print_d = 1'b1;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = SHOW;
                end
            end
            SHOW: begin
                // an aborted hold still acks so the requester is never stranded
                if (clear) begin
                    print_d = 1'b0;
                    ack_d   = NUM_REQ'(1) << grant_id;
                    state_d = ACK;
                end else if (cnt_q == '0) begin
                    ack_d   = NUM_REQ'(1) << grant_id;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                if (clear) begin
                    print_d = 1'b0;
                end
                ptr_d   = wrap_inc(grant_id);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Registered outputs: no combinational path from req to ack or disp_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_value <= '0;
            disp_print <= 1'b0;
            grant_id   <= '0;
            ack        <= '0;
            busy       <= 1'b0;
        end else begin
            disp_value <= value_d;
            disp_print <= print_d;
            grant_id   <= gid_d;
            ack        <= ack_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler (NUM_REQ=4, HOLD_CYCLES=4).
module tb_display_scheduler;

    localparam int HOLD = 4;

    typedef struct {
        logic [3:0]  req;
        logic [1:0]  gid;
        logic [15:0] val;
    } vec_t;

    typedef struct {
        logic [3:0] ack;
        logic [1:0] gid;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0][15:0] req_value;
    logic             clear;
    logic [3:0]       ack;
    logic [15:0]      disp_value;
    logic             disp_print;
    logic [1:0]       grant_id;
    logic             busy;

    int  n_pass  = 0;
    int  n_total = 0;
    int  cyc     = 0;
    sb_t sb[$];
    vec_t vecs[9];

    display_scheduler #(
        .NUM_REQ     (4),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_value  (req_value),
        .clear      (clear),
        .ack        (ack),
        .disp_value (disp_value),
        .disp_print (disp_print),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out at t=%0t", name, $time);
    endtask

    // Scoreboard: every ack pulse must match the oldest outstanding grant.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: got 0x%0h, expected none at t=%0t", ack, $time);
            end else begin
                e = sb.pop_front();
                check("sb_ack", ack, e.ack);
                check("sb_ack_gid", grant_id, e.gid);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at the grant negedge.
    task automatic drive_and_grant(input logic [3:0] r, input logic [1:0] g, input logic [15:0] v);
        sb_t e;
        e.ack = 4'b0001 << g;
        e.gid = g;
        sb.push_back(e);
        req = r;
        @(negedge clk);
        check("grant_busy", busy, 1);
        check("grant_id", grant_id, g);
        check("grant_value", disp_value, v);
        check("grant_print", disp_print, 1);
    endtask

    // Remaining SHOW cycles, the ACK cycle (req dropped there), then IDLE.
    task automatic finish_hold(input logic [15:0] v);
        for (int i = 1; i < HOLD; i++) begin
            @(negedge clk);
            check("show_busy", busy, 1);
            check("show_noack", ack, 0);
            check("show_value", disp_value, v);
        end
        @(negedge clk);
        check("ack_busy", busy, 1);
        check("ack_seen", ack != 4'b0000, 1);
        req = 4'b0000;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("sb_drained", sb.size(), 0);
        check("idle_value", disp_value, v);
        check("idle_print", disp_print, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        clear = 1'b0;
        @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   prev_cyc;
        logic prev_busy;
        logic found;
        sb_t  e;

        vecs[0] = '{4'b0001, 2'd0, 16'hFF85};
        vecs[1] = '{4'b0001, 2'd0, 16'hFF85};
        vecs[2] = '{4'b0110, 2'd1, 16'h002A};
        vecs[3] = '{4'b1001, 2'd3, 16'h8000};
        vecs[4] = '{4'b1001, 2'd0, 16'hFF85};
        vecs[5] = '{4'b1001, 2'd3, 16'h8000};
        vecs[6] = '{4'b0100, 2'd2, 16'h1234};
        vecs[7] = '{4'b1110, 2'd3, 16'h8000};
        vecs[8] = '{4'b1110, 2'd1, 16'h002A};

        rst_n        = 1'b0;
        req          = 4'b0000;
        clear        = 1'b0;
        req_value[0] = 16'hFF85;
        req_value[1] = 16'h002A;
        req_value[2] = 16'h1234;
        req_value[3] = 16'h8000;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_value", disp_value, 0);
        check("rst_print", disp_print, 0);
        check("rst_ack", ack, 0);
        check("rst_gid", grant_id, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        // single requests, sparse patterns and pointer wrap
        for (int i = 0; i < 9; i++) begin
            drive_and_grant(vecs[i].req, vecs[i].gid, vecs[i].val);
            finish_hold(vecs[i].val);
        end

        // value latched at grant ignores later req_value changes
        drive_and_grant(4'b0010, 2'd1, 16'h002A);
        req_value[1] = 16'h0063;
        finish_hold(16'h002A);
        drive_and_grant(4'b0010, 2'd1, 16'h0063);
        finish_hold(16'h0063);

        // clear in IDLE beats a simultaneous request, grant follows next cycle
        req   = 4'b0001;
        clear = 1'b1;
        e.ack = 4'b0001;
        e.gid = 2'd0;
        sb.push_back(e);
        @(negedge clk);
        check("clr_idle_busy", busy, 0);
        check("clr_idle_print", disp_print, 0);
        check("clr_idle_value", disp_value, 16'h0063);
        clear = 1'b0;
        @(negedge clk);
        check("clr_regrant_busy", busy, 1);
        check("clr_regrant_gid", grant_id, 0);
        check("clr_regrant_print", disp_print, 1);
        check("clr_regrant_value", disp_value, 16'hFF85);
        finish_hold(16'hFF85);

        // clear during the second SHOW cycle aborts the hold but still acks
        drive_and_grant(4'b0100, 2'd2, 16'h1234);
        @(negedge clk);
        check("clr_show_busy1", busy, 1);
        check("clr_show_noack", ack, 0);
        clear = 1'b1;
        @(negedge clk);
        check("clr_show_print", disp_print, 0);
        check("clr_show_ack", ack, 4'b0100);
        check("clr_show_busy2", busy, 1);
        clear = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        check("clr_show_idle", busy, 0);
        check("clr_show_value", disp_value, 16'h1234);
        check("clr_show_sb", sb.size(), 0);

        // asynchronous reset mid-SHOW: outputs clear at once, no ack
        drive_and_grant(4'b0010, 2'd1, 16'h0063);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_value", disp_value, 0);
        check("arst_print", disp_print, 0);
        check("arst_gid", grant_id, 0);
        check("arst_busy", busy, 0);
        check("arst_ack", ack, 0);
        sb.delete();
        req = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            check("arst_noack", ack, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < HOLD + 2; i++) begin
            @(negedge clk);
            check("arst_release_noack", ack, 0);
            check("arst_release_idle", busy, 0);
        end
        // pointer is back at 0, so 0110 must go to index 1
        drive_and_grant(4'b0110, 2'd1, 16'h0063);
        finish_hold(16'h0063);
        drive_and_grant(4'b0100, 2'd2, 16'h1234);
        finish_hold(16'h1234);

        // fairness: all requesters held high
        apply_reset();
        req       = 4'b1111;
        prev_cyc  = 0;
        prev_busy = busy;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (busy && !prev_busy) begin
                    found     = 1'b1;
                    prev_busy = busy;
                    break;
                end
                prev_busy = busy;
            end
            if (!found) begin
                timeout_fail("fair_grant");
            end else begin
                check("fair_gid", grant_id, k % 4);
                e.ack = 4'b0001 << (k % 4);
                e.gid = 2'(k % 4);
                sb.push_back(e);
                if (k > 0) check("fair_period", cyc - prev_cyc, HOLD + 2);
                prev_cyc = cyc;
            end
        end
        found = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (ack !== 4'b0000) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("fair_last_ack");
        req = 4'b0000;
        @(negedge clk);
        check("fair_idle", busy, 0);
        check("fair_sb", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the six-digit seven-segment display between several requesters (stack top, ALU result, error code, debug probe). Each requester posts a signed value. The scheduler grants one requester at a time in round-robin order and latches that value. It drives the latched value and print enable into valueToDisplay for a fixed hold time, then acknowledges the requester. It sits between the calculator core and the board display logic.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 50_000_000, cycles each granted value stays on the display (≥1; default is 1 s at 50 MHz)
- CNT_W, $clog2(HOLD_CYCLES+1), hold counter width (derived; do not override)
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset: asynchronous, active-low
- req  in  NUM_REQ  per-requester display request; level
- req_value  in  NUM_REQ×VALUE_W  per-requester signed value; VALUE_W from specs.vh
- clear  in  1  synchronous blank/abort command
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- disp_value  out  VALUE_W  value to valueToDisplay.value
- disp_print  out  1  to valueToDisplay.print_it
- grant_id  out  $clog2(NUM_REQ)  index of the current/last grant
- busy  out  1  high in SHOW and ACK

## Operation
- States: IDLE, SHOW, ACK.
- Reset values: state IDLE, disp_value 0, disp_print 0, ack 0, grant_id 0, busy 0. The round-robin pointer resets to 0.
- IDLE:
  - If any req is set, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that req_value into disp_value, set grant_id, set disp_print=1.
  - Load the counter with HOLD_CYCLES-1 and go to SHOW.
  - If no req is set, stay in IDLE; disp_value and disp_print keep their last values, so the last value stays displayed.
- SHOW:
  - Decrement the counter each cycle; at count 0 go to ACK.
  - req_value changes after the grant are ignored.
  - Dropping req mid-SHOW does not shorten the hold.
- ACK:
  - ack[grant_id]=1 for exactly this cycle.
  - The pointer becomes grant_id+1 mod NUM_REQ.
  - Go to IDLE.
- Requester contract:
  - Hold req until ack is seen.
  - Drop req in the cycle after ack, or keep it high to re-request.
  - A re-request competes fairly behind the others.
- clear:
  - In IDLE: disp_print goes to 0 next cycle; disp_value is unchanged.
  - In SHOW: abort the hold, disp_print goes to 0, go to ACK. The in-flight requester still gets its ack, so no requester is left waiting.
  - In ACK: the ack proceeds and disp_print goes to 0.
  - A new grant sets disp_print back to 1.
- Simultaneous clear and a new request in IDLE: clear wins for that cycle and no grant is made; arbitration resumes the next cycle.
- Arithmetic: the counter is unsigned CNT_W and never wraps; leaving SHOW at 0 prevents underflow. The pointer wraps modulo NUM_REQ, including non-powers of two.

## Timing
- Grant latency: req sampled high at edge T in IDLE → disp_value, disp_print, grant_id and busy are valid from edge T.
- The display holds the value for exactly HOLD_CYCLES cycles (SHOW), followed by one ACK cycle.
- With HOLD_CYCLES=1, SHOW lasts one cycle.
- Minimum per-grant period is HOLD_CYCLES+2 cycles (SHOW + ACK + IDLE).
- All outputs are registered; there is no combinational path from req to ack or to disp_*.
- An rst_n assertion mid-SHOW clears all outputs immediately (asynchronous); no ack is issued.

## Structure
- specs.vh additions:
  - disp_sched_state_t enum (IDLE, SHOW, ACK)
  - DISP_HOLD_DEFAULT constant
  - VALUE_W (existing)
- One sub-module, rr_pick: a purely combinational round-robin selector.
  - Inputs: req vector and pointer.
  - Outputs: found and index.
  - Reused by future shared-resource arbiters.
- Top level: FSM, hold counter, value latch, pointer register.

## Test plan
Bench parameters: NUM_REQ=4, HOLD_CYCLES=4, VALUE_W=16.
- Single request: req=0001, req_value[0]=16'hFF85 (−123) → disp_value=FF85 and disp_print=1 one edge later. Hold for 4 cycles, then ack=0001 for 1 cycle. The value stays displayed in IDLE.
- Fairness: req=1111 held continuously → grant_id sequence 0,1,2,3,0, one grant every 6 cycles. Each ack is one-hot and matches.
- Pointer wrap with sparse requests: after a grant to index 3, req=1001 → the next grant is 0, then 3.
- Value stability: change req_value[1] from 42 to 99 mid-SHOW → disp_value stays 42 until the next grant.
- clear mid-SHOW at cycle 2 → disp_print=0 next edge, ack pulses the following cycle, and the total busy time is 3 cycles.
- Asynchronous reset mid-SHOW: drop rst_n between edges → all outputs are 0 immediately and no ack appears. After release, req=0100 is granted to index 2 from pointer 0.
